// File: rtl/pipeline_ctrl.sv
// Hazard/redirect controller: merges stage stall requests and sequences trap/mret redirects.
// Optional stall watchdog is compiled in when STALL_WDOG_EN is defined.
module pipeline_ctrl #(
  parameter int WIDTH         = 32,
  parameter int REFILL_CYCLES = 1,
  parameter int WDOG_LIMIT    = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_req_id,
  input  logic             stall_req_ex,
  input  logic             stall_req_mem,
  input  logic             trap_req,
  input  logic [WIDTH-1:0] trap_vector,
  input  logic             mret_req,
  input  logic [WIDTH-1:0] mepc,
  output logic [4:0]       ctrl_stall,
  output logic             ctrl_flush,
  output logic             ctrl_pc_re,
  output logic [WIDTH-1:0] ctrl_new_pc,
  output logic             redirect_busy,
  output logic             stall_timeout
);

  localparam int CW = (REFILL_CYCLES < 2) ? 1 : $clog2(REFILL_CYCLES + 1);

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_REFILL} state_t;

  state_t           r_state, w_state_next;
  logic             r_pend, w_pend_next;
  logic [WIDTH-1:0] r_target, w_target_next;
  logic [WIDTH-1:0] r_new_pc, w_new_pc_next;
  logic [CW-1:0]    r_cnt, w_cnt_next;

  logic [4:0]       w_stall_pri, w_stall;
  logic             w_req, w_pend_any;
  logic [WIDTH-1:0] w_target_any;

  always_comb begin
    w_stall_pri = 5'b00000;
    if (stall_req_mem)     w_stall_pri = 5'b11111;
    else if (stall_req_ex) w_stall_pri = 5'b01111;
    else if (stall_req_id) w_stall_pri = 5'b00111;
    // A flush cycle kills everything, so no stage may be held while it happens.
    w_stall = (!rst_n || r_state == S_FLUSH) ? 5'b00000 : w_stall_pri;
  end

  // Merge the stored request with one arriving this cycle; trap beats mret, newest wins.
  always_comb begin
    w_req        = trap_req | mret_req;
    w_pend_any   = r_pend | w_req;
    w_target_any = trap_req ? trap_vector : (mret_req ? mepc : r_target);
  end

  always_comb begin
    w_state_next  = r_state;
    w_pend_next   = w_pend_any;
    w_target_next = w_target_any;
    w_new_pc_next = r_new_pc;
    w_cnt_next    = r_cnt;
    case (r_state)
      S_RUN: begin
        if (w_pend_any && !stall_req_mem) begin
          w_state_next  = S_FLUSH;
          w_pend_next   = 1'b0;
          w_new_pc_next = w_target_any;
        end
      end
      S_FLUSH: begin
        w_state_next = S_REFILL;
        w_cnt_next   = CW'(REFILL_CYCLES);
      end
      S_REFILL: begin
        if (trap_req && !stall_req_mem) begin
          w_state_next  = S_FLUSH;
          w_pend_next   = 1'b0;
          w_new_pc_next = w_target_any;
        end else if (!w_stall[0]) begin
          if (r_cnt == CW'(1)) begin
            if (w_pend_any) begin
              w_state_next  = S_FLUSH;
              w_pend_next   = 1'b0;
              w_new_pc_next = w_target_any;
            end else begin
              w_state_next = S_RUN;
            end
          end else begin
            w_cnt_next = r_cnt - CW'(1);
          end
        end
      end
      default: w_state_next = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_RUN;
      r_pend   <= 1'b0;
      r_target <= '0;
      r_new_pc <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_next;
      r_pend   <= w_pend_next;
      r_target <= w_target_next;
      r_new_pc <= w_new_pc_next;
      r_cnt    <= w_cnt_next;
    end
  end

  assign ctrl_stall    = w_stall;
  assign ctrl_flush    = (r_state == S_FLUSH);
  assign ctrl_pc_re    = (r_state == S_REFILL);
  assign redirect_busy = (r_state != S_RUN);
  assign ctrl_new_pc   = r_new_pc;

`ifdef STALL_WDOG_EN
  logic [7:0] r_wdog;
  logic       w_wdog_hit;

  // Fires in the cycle that completes the run of WDOG_LIMIT consecutive stalls.
  assign w_wdog_hit = (w_stall != 5'b00000) && (r_wdog == 8'(WDOG_LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     r_wdog <= 8'd0;
    else if (w_stall == 5'b00000)   r_wdog <= 8'd0;
    else if (w_wdog_hit)            r_wdog <= 8'd0;
    else if (r_wdog != 8'hFF)       r_wdog <= r_wdog + 8'd1;
  end

  assign stall_timeout = w_wdog_hit;
`else
  assign stall_timeout = 1'b0;
`endif

endmodule
